// File: rtl/thermal_head_driver.sv
// thermal_head_driver: serialises one parallel dot line MSB-first onto the
// thermal-head bus, then pulses latch and (optionally) the DST strobe.
`default_nettype none

module thermal_head_driver #(
  parameter int HEAD_WIDTH   = 384,
  parameter int CLK_DIV      = 4,
  parameter int GUARD_CYCLES = 16,
  parameter int LATCH_CYCLES = 4,
  parameter int DST_CYCLES   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [HEAD_WIDTH-1:0] line_data,
  input  logic                  line_burn,
  input  logic                  line_valid,
  output logic                  line_ready,
  output logic                  mech_clk,
  output logic                  mech_data,
  output logic                  mech_latch,
  output logic                  mech_dst,
  output logic                  busy,
  output logic                  line_done
);

  localparam int PH_MAX_A = (CLK_DIV > GUARD_CYCLES) ? CLK_DIV : GUARD_CYCLES;
  localparam int PH_MAX_B = (LATCH_CYCLES > DST_CYCLES) ? LATCH_CYCLES : DST_CYCLES;
  localparam int PH_MAX   = (PH_MAX_A > PH_MAX_B) ? PH_MAX_A : PH_MAX_B;
  localparam int PH_W     = $clog2(PH_MAX + 1);
  localparam int BIT_W    = $clog2(HEAD_WIDTH + 1);

  localparam logic [PH_W-1:0]  PH_CLK   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_GUARD = PH_W'(GUARD_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LATCH = PH_W'(LATCH_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_DST   = PH_W'(DST_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(HEAD_WIDTH);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    GUARD    = 3'd3,
    LATCH    = 3'd4,
    DST      = 3'd5
  } state_t;

  state_t                state;
  logic [HEAD_WIDTH-1:0] shift_reg;
  logic [HEAD_WIDTH-1:0] shifted;
  logic [BIT_W-1:0]      bit_cnt;
  logic [PH_W-1:0]       ph_cnt;
  logic                  burn;

  assign shifted = shift_reg << 1;

  // Outputs are assigned for the state being entered, so every mech_* pin
  // comes straight from a flop with no path from the line_* inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      ph_cnt     <= '0;
      burn       <= 1'b0;
      line_ready <= 1'b0;
      busy       <= 1'b0;
      mech_clk   <= 1'b0;
      mech_data  <= 1'b0;
      mech_latch <= 1'b0;
      mech_dst   <= 1'b0;
      line_done  <= 1'b0;
    end else begin
      line_done <= 1'b0;
      case (state)
        IDLE: begin
          line_ready <= 1'b1;
          busy       <= 1'b0;
          if (line_valid && line_ready) begin
            shift_reg  <= line_data;
            burn       <= line_burn;
            bit_cnt    <= BIT_ALL;
            ph_cnt     <= PH_CLK;
            mech_data  <= line_data[HEAD_WIDTH-1];
            mech_clk   <= 1'b0;
            line_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (ph_cnt == '0) begin
            ph_cnt   <= PH_CLK;
            mech_clk <= 1'b1;
            state    <= SHIFT_HI;
          end else begin
            ph_cnt <= ph_cnt - PH_ONE;
          end
        end
        SHIFT_HI: begin
          if (ph_cnt == '0) begin
            shift_reg <= shifted;
            bit_cnt   <= bit_cnt - BIT_ONE;
            mech_clk  <= 1'b0;
            if (bit_cnt == BIT_ONE) begin
              ph_cnt    <= PH_GUARD;
              mech_data <= 1'b0;
              state     <= GUARD;
            end else begin
              ph_cnt    <= PH_CLK;
              mech_data <= shifted[HEAD_WIDTH-1];
              state     <= SHIFT_LO;
            end
          end else begin
            ph_cnt <= ph_cnt - PH_ONE;
          end
        end
        GUARD: begin
          if (ph_cnt == '0) begin
            ph_cnt     <= PH_LATCH;
            mech_latch <= 1'b1;
            line_done  <= (LATCH_CYCLES == 1) && !burn;
            state      <= LATCH;
          end else begin
            ph_cnt <= ph_cnt - PH_ONE;
          end
        end
        LATCH: begin
          if (ph_cnt == '0) begin
            mech_latch <= 1'b0;
            if (burn) begin
              ph_cnt    <= PH_DST;
              mech_dst  <= 1'b1;
              line_done <= (DST_CYCLES == 1);
              state     <= DST;
            end else begin
              line_ready <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end else begin
            ph_cnt    <= ph_cnt - PH_ONE;
            line_done <= !burn && (ph_cnt == PH_ONE);
          end
        end
        DST: begin
          if (ph_cnt == '0) begin
            mech_dst   <= 1'b0;
            line_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            ph_cnt    <= ph_cnt - PH_ONE;
            line_done <= (ph_cnt == PH_ONE);
          end
        end
        default: begin
          mech_clk   <= 1'b0;
          mech_data  <= 1'b0;
          mech_latch <= 1'b0;
          mech_dst   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_thermal_head_driver.sv
// tb_thermal_head_driver: directed checks of serial timing, latch/DST pulses,
// handshake robustness and reset behaviour with W=8, C=2, G=4, L=2, D=6.
`default_nettype none

module tb_thermal_head_driver;

  localparam int W = 8;
  localparam int N = 100;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] line_data;
  logic         line_burn;
  logic         line_valid;
  logic         line_ready, mech_clk, mech_data, mech_latch, mech_dst, busy, line_done;

  always #5 clk = ~clk;

  thermal_head_driver #(
    .HEAD_WIDTH(W), .CLK_DIV(2), .GUARD_CYCLES(4), .LATCH_CYCLES(2), .DST_CYCLES(6)
  ) dut (
    .clk(clk), .reset(reset), .line_data(line_data), .line_burn(line_burn),
    .line_valid(line_valid), .line_ready(line_ready), .mech_clk(mech_clk),
    .mech_data(mech_data), .mech_latch(mech_latch), .mech_dst(mech_dst),
    .busy(busy), .line_done(line_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle samples, index k = cycle T+k after the accepting edge T.
  logic clk_s[N], data_s[N], latch_s[N], dst_s[N], done_s[N], busy_s[N], ready_s[N];

  int          rises, first_rise, last_rise;
  logic [31:0] bits;
  int          latch_cnt, latch_first, latch_last;
  int          dst_cnt, dst_first, dst_last;
  int          done_cnt, done_pos, busy_cnt, overlap, bad_clk;

  task automatic record(input int n);
    clk_s[0] = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      clk_s[k]   = mech_clk;
      data_s[k]  = mech_data;
      latch_s[k] = mech_latch;
      dst_s[k]   = mech_dst;
      done_s[k]  = line_done;
      busy_s[k]  = busy;
      ready_s[k] = line_ready;
    end
  endtask

  task automatic analyze(input int n);
    rises = 0; first_rise = -1; last_rise = -1; bits = '0;
    latch_cnt = 0; latch_first = -1; latch_last = -1;
    dst_cnt = 0; dst_first = -1; dst_last = -1;
    done_cnt = 0; done_pos = -1; busy_cnt = 0; overlap = 0; bad_clk = 0;
    for (int k = 1; k <= n; k++) begin
      if (!clk_s[k-1] && clk_s[k]) begin
        rises++;
        bits = {bits[30:0], data_s[k]};
        if (first_rise < 0) first_rise = k;
        last_rise = k;
      end
      if (latch_s[k]) begin
        latch_cnt++;
        if (latch_first < 0) latch_first = k;
        latch_last = k;
      end
      if (dst_s[k]) begin
        dst_cnt++;
        if (dst_first < 0) dst_first = k;
        dst_last = k;
      end
      if (done_s[k]) begin
        done_cnt++;
        done_pos = k;
      end
      if (busy_s[k]) busy_cnt++;
      if (latch_s[k] && dst_s[k]) overlap++;
      if (clk_s[k] && (latch_s[k] || dst_s[k] || !busy_s[k])) bad_clk++;
    end
  endtask

  // Waits (bounded) for line_ready, then offers a line for exactly one edge.
  // Returns at #1 after the accepting edge, i.e. inside cycle T+1.
  task automatic start(input logic [W-1:0] d, input logic b);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!line_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!line_ready) check("start_timeout", 32'd0, 32'd1);
    line_data  = d;
    line_burn  = b;
    line_valid = 1'b1;
    @(posedge clk);
    #1;
    line_valid = 1'b0;
  endtask

  logic [6:0] acc;

  initial begin
    reset      = 1'b0;
    line_valid = 1'b1;
    line_data  = 8'hA5;
    line_burn  = 1'b1;

    // Reset held with a line offered: everything quiet, not ready.
    repeat (2) @(negedge clk);
    acc = '0;
    repeat (4) begin
      @(negedge clk);
      acc = acc | {mech_clk, mech_data, mech_latch, mech_dst, line_done, busy, line_ready};
    end
    check("rst_outputs", 32'(acc), 32'd0);
    line_valid = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", 32'(line_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);

    // Line A5 with burn.
    start(8'hA5, 1'b1);
    record(50);
    analyze(50);
    check("t1_rises", rises, 8);
    check("t1_bits", bits & 32'hFF, 32'hA5);
    check("t1_first_rise", first_rise, 3);
    check("t1_last_rise", last_rise, 31);
    check("t1_latch_first", latch_first, 37);
    check("t1_latch_last", latch_last, 38);
    check("t1_latch_cnt", latch_cnt, 2);
    check("t1_dst_first", dst_first, 39);
    check("t1_dst_last", dst_last, 44);
    check("t1_dst_cnt", dst_cnt, 6);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_pos", done_pos, 44);
    check("t1_busy_cnt", busy_cnt, 44);
    check("t1_ready_after", 32'(ready_s[45]), 32'd1);
    check("t1_overlap", overlap, 0);
    check("t1_bad_clk", bad_clk, 0);

    // Line FF without burn.
    start(8'hFF, 1'b0);
    record(45);
    analyze(45);
    check("t2_bits", bits & 32'hFF, 32'hFF);
    check("t2_rises", rises, 8);
    check("t2_dst_cnt", dst_cnt, 0);
    check("t2_latch_first", latch_first, 37);
    check("t2_latch_last", latch_last, 38);
    check("t2_done_pos", done_pos, 38);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_busy_cnt", busy_cnt, 38);

    // Input churn while busy, then a second line queued behind the first.
    start(8'h5A, 1'b0);
    fork
      record(90);
      begin
        repeat (10) @(posedge clk);
        repeat (25) begin
          @(negedge clk);
          line_valid = ~line_valid;
          line_data  = W'($urandom);
          line_burn  = 1'b1;
        end
        line_valid = 1'b0;
        start(8'h81, 1'b0);
      end
    join
    analyze(90);
    check("t3_rises", rises, 16);
    check("t3_bits", bits & 32'hFFFF, 32'h5A81);
    check("t3_dst_cnt", dst_cnt, 0);
    check("t3_gap_idle", 32'(busy_s[39]), 32'd0);
    check("t3_gap_ready", 32'(ready_s[39]), 32'd1);
    check("t3_second_busy", 32'(busy_s[40]), 32'd1);
    check("t3_busy_cnt", busy_cnt, 76);
    check("t3_done_cnt", done_cnt, 2);
    check("t3_done_pos", done_pos, 77);

    // Reset during bit 4, then a clean line.
    start(8'hFF, 1'b0);
    repeat (17) @(posedge clk);
    #1;
    check("t4_pre_data", 32'(mech_data), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t4_async_outputs",
          32'({mech_clk, mech_data, mech_latch, mech_dst, line_done, busy, line_ready}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    start(8'h3C, 1'b0);
    record(45);
    analyze(45);
    check("t4_rises", rises, 8);
    check("t4_bits", bits & 32'hFF, 32'h3C);
    check("t4_latch_first", latch_first, 37);
    check("t4_done_pos", done_pos, 38);
    check("t4_busy_cnt", busy_cnt, 38);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/thermal_head_driver.md
# thermal_head_driver

Drives the serial thermal-head mechanism interface (mech_clk, mech_data, mech_latch, mech_dst) from a parallel dot line. It accepts one HEAD_WIDTH-bit line per valid/ready handshake and serialises it MSB-first on mech_clk rising edges. It then pulses the latch and, optionally, the strobe (DST). The block is the transmit end of the print-mechanism bus: it is used as the stimulus generator for the head-capture model and as the print-engine side in loopback benches.

## Interface
- HEAD_WIDTH, 384, dots per line; bits shifted per line.
- CLK_DIV, 4, clk cycles per mech_clk half-period (≥1).
- GUARD_CYCLES, 16, idle clk cycles between last mech_clk fall and latch assert (≥1; covers receiver FIFO drain).
- LATCH_CYCLES, 4, mech_latch high width in clk cycles (≥1).
- DST_CYCLES, 64, mech_dst high width in clk cycles (≥1).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- line_data  in  HEAD_WIDTH  dot line; bit HEAD_WIDTH-1 shifted first.
- line_burn  in  1  sampled with line_data; 1 = run the DST phase after the latch.
- line_valid  in  1  line offered.
- line_ready  out  1  block idle and able to accept a line.
- mech_clk  out  1  shift clock; data sampled by the receiver on the rising edge.
- mech_data  out  1  serial dot data.
- mech_latch  out  1  latch pulse, active high; the receiver captures on the falling edge.
- mech_dst  out  1  strobe, active high.
- busy  out  1  inverse of line_ready.
- line_done  out  1  one-cycle pulse on the last cycle of a transaction.

## Operation
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, GUARD, LATCH, DST.
- IDLE: line_ready=1. On a clk edge with line_valid && line_ready:
  - load the shift register with line_data;
  - capture line_burn;
  - set the bit counter to HEAD_WIDTH and the phase counter to CLK_DIV-1;
  - go to SHIFT_LO.
- SHIFT_LO: mech_clk=0 and mech_data=shift register MSB for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: mech_clk=1 for CLK_DIV cycles; mech_data holds its value. On exit:
  - shift the register left by 1 and decrement the bit counter;
  - if the counter reaches 0, go to GUARD; otherwise go to SHIFT_LO.
- GUARD: mech_clk=0, mech_data=0, for GUARD_CYCLES cycles. Then go to LATCH.
- LATCH: mech_latch=1 for LATCH_CYCLES cycles. Then go to DST if burn is captured, else to IDLE.
- DST: mech_dst=1 for DST_CYCLES cycles. Then go to IDLE.
- line_done is asserted on the final cycle of LATCH (burn=0) or of DST (burn=1).
- Outputs are registered, with no combinational path from inputs to mech_* outputs. mech_latch and mech_dst are never high at the same time. mech_clk never toggles outside SHIFT_*.
- line_valid while busy is ignored. line_data, line_burn and line_valid changing mid-transaction have no effect.
- Counters are sized $clog2(max+1). The bit counter never wraps; no partial lines are sent.
- Reset (any time, including mid-shift) takes effect immediately:
  - state=IDLE, with the shift register and all counters cleared;
  - mech_clk=0, mech_data=0, mech_latch=0, mech_dst=0;
  - line_done=0, busy=0, line_ready=1 once reset deasserts.
- A reset mid-DST truncates the strobe; there is no minimum pulse width after reset.

## Timing
- Notation: C=CLK_DIV, W=HEAD_WIDTH, G=GUARD_CYCLES, L=LATCH_CYCLES, D=DST_CYCLES.
- Handshake at edge T: line_ready=0 and busy=1 from T+1.
- Bit i (i=0 first, from line_data[W-1-i]):
  - mech_data is valid from T+1+2Ci;
  - mech_clk rises at T+1+2Ci+C;
  - mech_clk falls at T+1+2C(i+1).
- Data setup and hold relative to the mech_clk rise are each ≥ C clk cycles.
- mech_latch is high over cycles T+1+2CW+G to T+2CW+G+L.
- With burn=1, mech_dst is high over the D cycles immediately after latch deassert.
- line_ready returns 1 on the cycle after line_done. Back-to-back lines are therefore separated by one IDLE cycle.
- Total busy cycles: 2CW+G+L (+D if burn).

## Test plan
- Reset check: hold reset low with line_valid=1 → all mech_* outputs are 0, line_ready=0 during reset, line_ready=1 after release, no mech_clk edges.
- Single line, W=8, C=2, G=4, L=2, D=6, line_data=8'hA5, burn=1:
  - mech_data sampled at the 8 mech_clk rises reads 1,0,1,0,0,1,0,1;
  - the rises fall at T+3, T+7, …, T+31;
  - mech_latch is high on cycles T+37..T+38;
  - mech_dst is high on T+39..T+44;
  - line_done pulses at T+44.
- burn=0 with line 8'hFF → no mech_dst activity; line_done on the last latch cycle; busy for exactly 38 cycles.
- Handshake abuse: toggle line_valid and change line_data mid-shift → shifted bits match the originally accepted line; the second line is accepted only after line_ready returns; the gap between lines is exactly 1 IDLE cycle.
- Mid-shift reset after bit 3 → outputs are 0 within the reset assertion. A following line 8'h3C is transmitted completely with no residue from the aborted line.
- Loopback into the head-capture model with W=384 and random lines (×50):
  - the captured latch contents equal line_data after each latch fall;
  - head_active follows mech_dst one clk later;
  - no receiver FIFO overflow.
